vdp_dma_master: RTL

Bus-initiator half of the 68000-side memory protocol: the VDP's DMA engine becomes 68000 bus master, issues word read cycles against the main memory responder, and streams the fetched words toward VRAM. It sits between the VDP register block (which programs source/length and pulses start) and the 68000 bus fabric (bus request/grant plus AS/RW/UDS/LDS/DTACK cycles).

---
 rtl/genesis_bus_pkg.sv | 28 ++
 rtl/vdp_dma_master.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/genesis_bus_pkg.sv
// Shared 68000-bus definitions for the VDP DMA initiator: state encoding,
// address width, 128 KB RAM wrap mask and strobe levels.
package genesis_bus_pkg;

    localparam int          M68_AW        = 24;
    localparam logic [16:0] RAM_WRAP_MASK = 17'h1FFFF;
    localparam logic        STROBE_ON     = 1'b0;
    localparam logic        STROBE_OFF    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        ADDR,
        WAIT_ACK,
        WAIT_DONE,
        PUSH,
        GAP,
        FINISH
    } dma_state_t;

    // Source pointer steps one word inside a 128 KB window; upper bits are frozen.
    function automatic logic [M68_AW-1:0] next_word_addr(input logic [M68_AW-1:0] a);
        logic [16:0] lo;
        lo = (a[16:0] + 17'd2) & RAM_WRAP_MASK;
        return {a[M68_AW-1:17], lo};
    endfunction

endpackage

// File: rtl/vdp_dma_master.sv
// VDP DMA bus initiator: takes the 68000 bus, runs word read cycles from
// main memory and hands each fetched word to the VRAM side.
module vdp_dma_master
    import genesis_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int GAP_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] src_addr,
    input  logic [15:0] length,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        bus_req,
    input  logic        bus_grant,
    output logic        M68_as,
    output logic        M68_rw,
    output logic        M68_uds,
    output logic        M68_lds,
    output logic [31:0] M68_addr,
    input  logic        M68_dtack,
    input  logic [15:0] M68_data_in,
    output logic [15:0] word_out,
    output logic        word_valid,
    input  logic        word_ready
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

    dma_state_t        state_q, state_d;
    logic [M68_AW-1:0] addr_q, addr_d;
    logic [M68_AW-1:0] bus_addr_q, bus_addr_d;
    logic [16:0]       rem_q, rem_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [7:0]        gap_q, gap_d;
    logic [15:0]       word_q, word_d;
    logic as_q, as_d, strb_q, strb_d, bus_req_q, bus_req_d, busy_q, busy_d;
    logic done_q, done_d, error_q, error_d, wvalid_q, wvalid_d;
    logic completing;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        bus_addr_d = bus_addr_q;
        rem_d      = rem_q;
        tmo_d      = tmo_q;
        gap_d      = gap_q;
        word_d     = word_q;
        as_d       = as_q;
        strb_d     = strb_q;
        bus_req_d  = bus_req_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        wvalid_d   = wvalid_q;
        completing = (state_q == WAIT_DONE) && !M68_dtack;

        case (state_q)
            IDLE: if (start) begin
                addr_d    = src_addr & ~24'd1;
                rem_d     = (length == 16'd0) ? 17'h10000 : {1'b0, length};
                busy_d    = 1'b1;
                error_d   = 1'b0;
                bus_req_d = 1'b1;
                state_d   = REQ;
            end
            REQ: if (bus_grant) begin
                bus_addr_d = addr_q;
                state_d    = ADDR;
            end
            ADDR: begin
                as_d    = STROBE_ON;
                strb_d  = STROBE_ON;
                tmo_d   = '0;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: if (M68_dtack) state_d = WAIT_DONE;
            WAIT_DONE: if (completing) begin
                word_d   = M68_data_in;
                as_d     = STROBE_OFF;
                strb_d   = STROBE_OFF;
                wvalid_d = 1'b1;
                state_d  = PUSH;
            end
            PUSH: if (word_ready) begin
                wvalid_d = 1'b0;
                rem_d    = rem_q - 17'd1;
                addr_d   = next_word_addr(addr_q);
                if (rem_q == 17'd1) begin
                    bus_req_d = 1'b0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = FINISH;
                end else begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                // Bus release is only honoured here, between complete cycles.
                if (gap_q == GAP_LAST) begin
                    if (bus_grant) begin
                        bus_addr_d = addr_q;
                        state_d    = ADDR;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A cycle that completes on the same edge the budget runs out still counts.
        if ((state_q == WAIT_ACK || state_q == WAIT_DONE) && !completing) begin
            if (tmo_q == TMO_LAST) begin
                as_d      = STROBE_OFF;
                strb_d    = STROBE_OFF;
                bus_req_d = 1'b0;
                busy_d    = 1'b0;
                wvalid_d  = 1'b0;
                done_d    = 1'b1;
                error_d   = 1'b1;
                state_d   = IDLE;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            bus_addr_q <= '0;
            rem_q      <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
            word_q     <= '0;
            as_q       <= STROBE_OFF;
            strb_q     <= STROBE_OFF;
            bus_req_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            wvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            bus_addr_q <= bus_addr_d;
            rem_q      <= rem_d;
            tmo_q      <= tmo_d;
            gap_q      <= gap_d;
            word_q     <= word_d;
            as_q       <= as_d;
            strb_q     <= strb_d;
            bus_req_q  <= bus_req_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            wvalid_q   <= wvalid_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign bus_req    = bus_req_q;
    assign M68_as     = as_q;
    assign M68_rw     = 1'b1;
    assign M68_uds    = strb_q;
    assign M68_lds    = strb_q;
    assign M68_addr   = {8'h00, bus_addr_q};
    assign word_out   = word_q;
    assign word_valid = wvalid_q;

endmodule
